instr_sequencer: RTL and testbench

//  Multicycle control FSM for the 16-bit Tron core. Fetches an instruction over a req/ack

---
 rtl/instr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit Tron core.
// Define SEQ_TIMEOUT_EN to add the memory-wait timeout with sticky bus_err.
module instr_sequencer #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] ir,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             pc_en,
    output logic             imm_sel,
    output logic             sign_ext,
    output logic [3:0]       alu_op,
    output logic             flag_we,
    output logic             reg_we,
    output logic             wb_sel,
    output logic [15:0]      retired,
    output logic             bus_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] opc, ext;
    logic       is_rtype, is_imm, is_load, is_stor, is_cmp, is_flag, is_wr;
    logic       ir_load, retire, tmo;

    assign opc = ir[WIDTH-1 -: 4];
    assign ext = ir[7:4];

    always_comb begin
        is_rtype = (opc == 4'b0000);
        is_imm   = opc inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001,
                               4'b1011, 4'b1101, 4'b1000, 4'b1111};
        is_load  = (opc == 4'b0100) && (ext == 4'b0000);
        is_stor  = (opc == 4'b0100) && (ext == 4'b0100);
        is_cmp   = (is_rtype && ext == 4'b1011) || (opc == 4'b1011);
        is_flag  = (is_rtype && (ext inside {4'b0101, 4'b1001, 4'b1011})) ||
                   (opc inside {4'b0101, 4'b1001, 4'b1011});
        // Unrecognised opcodes and memory exts fall through as NOPs: no write-back.
        is_wr    = (is_rtype || is_imm || is_load) && !is_cmp;
    end

    assign sign_ext = opc inside {4'b0101, 4'b1001, 4'b1011};
    assign alu_op   = is_rtype ? ext : opc;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        pc_en     = 1'b0;
        imm_sel   = 1'b0;
        flag_we   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        ir_load   = 1'b0;
        retire    = 1'b0;
        case (state)
            S_FETCH: begin
                if (!tmo) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        pc_en     = 1'b1;
                        ir_load   = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                imm_sel   = is_imm;
                flag_we   = is_flag;
                state_nxt = (is_load || is_stor) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (tmo) begin
                    state_nxt = S_FETCH;
                end else begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = is_stor;
                    if (mem_ack) begin
                        retire    = is_stor;
                        state_nxt = is_stor ? S_FETCH : S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we    = is_wr;
                wb_sel    = is_load;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        // Asynchronous reset must silence the bus immediately, even mid-transfer.
        if (reset) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            pc_en    = 1'b0;
            imm_sel  = 1'b0;
            flag_we  = 1'b0;
            reg_we   = 1'b0;
            wb_sel   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load)
                ir <= mem_rdata;
            if (retire)
                retired <= retired + 16'd1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);
    logic [7:0] wcnt;

    // On expiry the FSM spends one cycle with mem_req low, then re-enters FETCH.
    assign tmo = ((state == S_FETCH) || (state == S_MEM)) && (wcnt == TMO_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt    <= '0;
            bus_err <= 1'b0;
        end else begin
            if (tmo)
                bus_err <= 1'b1;
            if (tmo || (state_nxt != state))
                wcnt <= '0;
            else if (mem_req && !mem_ack)
                wcnt <= wcnt + 8'd1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, random instruction stream, reset and wait corners.
module tb_instr_sequencer;

    typedef struct packed {
        logic       imm;
        logic       sext;
        logic       flag;
        logic       rwe;
        logic       ld;
        logic       st;
        logic [3:0] aop;
    } dec_t;

    typedef struct {
        logic [15:0] word;
        int          fw;
        int          mw;
        dec_t        d;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] ir;
    logic        mem_req, mem_we, addr_sel, pc_en, imm_sel, sign_ext;
    logic [3:0]  alu_op;
    logic        flag_we, reg_we, wb_sel, bus_err;
    logic [15:0] retired;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_ret = 16'd0;
    vec_t        vq[$];

    instr_sequencer #(.WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ir(ir), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .pc_en(pc_en), .imm_sel(imm_sel), .sign_ext(sign_ext), .alu_op(alu_op),
        .flag_we(flag_we), .reg_we(reg_we), .wb_sel(wb_sel),
        .retired(retired), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic dec_t mkd(input logic imm, input logic sext, input logic flag,
                                 input logic rwe, input logic ld, input logic st,
                                 input logic [3:0] aop);
        dec_t d;
        d = {imm, sext, flag, rwe, ld, st, aop};
        return d;
    endfunction

    // Reference decode from the instruction-set rules, using opcode bitmasks.
    function automatic dec_t model(input logic [15:0] w);
        logic [15:0] imm_m, arith_m;
        logic [3:0]  o, e;
        logic        rt, ld, st, cmp;
        dec_t        d;
        imm_m   = 16'hAB2E;   // opcodes 1,2,3,5,8,9,B,D,F
        arith_m = 16'h0A20;   // codes 5 (ADD), 9 (SUB), B (CMP)
        o  = w[15:12];
        e  = w[7:4];
        rt = (o == 4'h0);
        ld = (o == 4'h4) && (e == 4'h0);
        st = (o == 4'h4) && (e == 4'h4);
        cmp = rt ? (e == 4'hB) : (o == 4'hB);
        d.imm  = imm_m[o];
        d.sext = arith_m[o];
        d.flag = rt ? arith_m[e] : arith_m[o];
        d.rwe  = (rt || imm_m[o] || ld) && !cmp;
        d.ld   = ld;
        d.st   = st;
        d.aop  = rt ? e : o;
        return d;
    endfunction

    function automatic logic [7:0] outs();
        return {mem_req, mem_we, addr_sel, pc_en, imm_sel, flag_we, reg_we, wb_sel};
    endfunction

    // One clock: drive at posedge+1, compare at the negedge, return at the next posedge+1.
    task automatic step(input string nm, input logic ack, input logic [15:0] rd,
                        input logic [7:0] exp, input logic chk_dec, input dec_t d);
        mem_ack   = ack;
        mem_rdata = rd;
        @(negedge clk);
        chk({nm, " outs"}, {24'd0, outs()}, {24'd0, exp});
        if (chk_dec)
            chk({nm, " sext/aluop"}, {27'd0, sign_ext, alu_op}, {27'd0, d.sext, d.aop});
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] w, input int fw, input int mw, input dec_t d);
        for (int i = 0; i <= fw; i++)
            step("fetch", i == fw, (i == fw) ? w : 16'($urandom),
                 {1'b1, 1'b0, 1'b0, i == fw, 4'b0000}, 1'b0, d);
        step("decode", 1'($urandom), 16'($urandom), 8'h00, 1'b1, d);
        step("exec", 1'($urandom), 16'($urandom), {4'b0000, d.imm, d.flag, 2'b00}, 1'b1, d);
        if (d.ld || d.st)
            for (int i = 0; i <= mw; i++)
                step("mem", i == mw, 16'($urandom), {1'b1, d.st, 1'b1, 5'b00000}, 1'b1, d);
        if (!d.st)
            step("wb", 1'($urandom), 16'($urandom), {6'b000000, d.rwe, d.ld}, 1'b1, d);
        exp_ret++;
        chk("retired", {16'd0, retired}, {16'd0, exp_ret});
        chk("ir", {16'd0, ir}, {16'd0, w});
    endtask

    initial begin
        vq.push_back('{16'h55FF, 0, 0, mkd(1, 1, 1, 1, 0, 0, 4'h5)});  // ADDI
        vq.push_back('{16'h2280, 0, 0, mkd(1, 0, 0, 1, 0, 0, 4'h2)});  // ORI
        vq.push_back('{16'h4102, 0, 3, mkd(0, 0, 0, 1, 1, 0, 4'h4)});  // LOAD, 3 wait
        vq.push_back('{16'h4340, 0, 0, mkd(0, 0, 0, 0, 0, 1, 4'h4)});  // STOR
        vq.push_back('{16'h0152, 0, 0, mkd(0, 0, 1, 1, 0, 0, 4'h5)});  // ADD
        vq.push_back('{16'h01B3, 0, 0, mkd(0, 0, 1, 0, 0, 0, 4'hB)});  // CMP
        vq.push_back('{16'hB1FE, 0, 0, mkd(1, 1, 1, 0, 0, 0, 4'hB)});  // CMPI
        vq.push_back('{16'h6123, 0, 0, mkd(0, 0, 0, 0, 0, 0, 4'h6)});  // bad opcode
        vq.push_back('{16'h4170, 0, 0, mkd(0, 0, 0, 0, 0, 0, 4'h4)});  // bad mem ext
        vq.push_back('{16'hF1AB, 0, 0, mkd(1, 0, 0, 1, 0, 0, 4'hF)});  // LUI
        vq.push_back('{16'h5301, 2, 0, mkd(1, 1, 1, 1, 0, 0, 4'h5)});  // ADDI, fetch wait
        vq.push_back('{16'h4A01, 1, 1, mkd(0, 0, 0, 1, 1, 0, 4'h4)});  // LOAD
        vq.push_back('{16'h4C4F, 0, 2, mkd(0, 0, 0, 0, 0, 1, 4'h4)});  // STOR, wait

        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        #1;
        chk("rst outs", {24'd0, outs()}, 32'd0);
        chk("rst ir", {16'd0, ir}, 32'd0);
        chk("rst retired", {16'd0, retired}, 32'd0);
        chk("rst bus_err", {31'd0, bus_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; mem_ack = 1'b0;

        foreach (vq[i])
            run_instr(vq[i].word, vq[i].fw, vq[i].mw, vq[i].d);

        for (int n = 0; n < 200; n++) begin
            logic [3:0]  o, e;
            logic [15:0] w;
            o = 4'($urandom_range(0, 15));
            e = 4'($urandom_range(0, 15));
            if (o == 4'h4 && $urandom_range(0, 3) != 0)
                e = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h4;
            w = {o, 4'($urandom), e, 4'($urandom)};
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), model(w));
        end

        // Reset in the middle of a LOAD's memory phase.
        begin
            dec_t d;
            d = model(16'h4506);
            step("pre fetch", 1'b1, 16'h4506, 8'b1001_0000, 1'b0, d);
            step("pre decode", 1'b0, 16'h0000, 8'h00, 1'b1, d);
            step("pre exec", 1'b0, 16'h0000, 8'h00, 1'b1, d);
            mem_ack = 1'b0;
            @(negedge clk);
            chk("mid-mem outs", {24'd0, outs()}, {24'd0, 8'b1010_0000});
            reset = 1'b1;
            #1;
            chk("rst mid-mem outs", {24'd0, outs()}, 32'd0);
            chk("rst mid-mem retired", {16'd0, retired}, 32'd0);
            chk("rst mid-mem ir", {16'd0, ir}, 32'd0);
            mem_ack = 1'b1;
            #1;
            chk("rst ack pc_en", {31'd0, pc_en}, 32'd0);
            @(posedge clk);
            #1;
            reset = 1'b0; mem_ack = 1'b0;
            exp_ret = 16'd0;
            @(negedge clk);
            chk("post-rst fetch", {24'd0, outs()}, {24'd0, 8'b1000_0000});
            @(posedge clk);
            #1;
            run_instr(16'h5AFF, 0, 0, model(16'h5AFF));
        end

        // Memory that never acknowledges during FETCH.
        mem_ack = 1'b0;
        mem_rdata = 16'h1234;
        for (int c = 0; c < 10; c++) begin
            logic req_e, err_e;
`ifdef SEQ_TIMEOUT_EN
            req_e = (c != 4) && (c != 9);
            err_e = (c >= 5);
`else
            req_e = 1'b1;
            err_e = 1'b0;
`endif
            @(negedge clk);
            chk("stall outs", {24'd0, outs()}, {24'd0, req_e, 7'b000_0000});
            chk("stall bus_err", {31'd0, bus_err}, {31'd0, err_e});
            @(posedge clk);
            #1;
        end
        chk("stall ir", {16'd0, ir}, 32'h5AFF);
        chk("stall retired", {16'd0, retired}, {16'd0, exp_ret});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
